// File: rtl/cisc_core_multiciclo.sv
// Multicycle CISC core: register bank, ALSU with stored flags, PC/IR and a
// request/acknowledge memory port, sequenced by a fetch/decode/execute FSM.
module cisc_core_multiciclo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [3:0]        flags,
  output logic [ADDR_W-1:0] pc
);
  localparam int RA_W = $clog2(NREG);
  localparam int MSB  = DATA_W - 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_OPER, S_HALT} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   ir, ir_n;
  logic [ADDR_W-1:0]   pc_n, pc_inc;
  logic [3:0]          flags_n;
  logic                req_n, we_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   regs [NREG];

  logic [3:0]          op;
  logic [RA_W-1:0]     rd, ra, rb;
  logic [2:0]          f;
  logic [DATA_W-1:0]   a, b;
  logic [DATA_W:0]     sum, diff;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_cy, alu_ov;
  logic [3:0]          alu_flags;
  logic                jc_taken;
  logic                unused_ir;

  assign op        = ir[DATA_W-1 -: 4];
  assign rd        = ir[DATA_W-5 -: RA_W];
  assign ra        = ir[DATA_W-5-RA_W -: RA_W];
  assign rb        = ir[DATA_W-5-2*RA_W -: RA_W];
  assign f         = ir[2:0];
  assign unused_ir = ^ir;

  assign a      = regs[ra];
  assign b      = regs[rb];
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign pc_inc = pc + ADDR_W'(1);
  assign halted = (state == S_HALT);

  // flags is {cy, ov, msb, z}; selector 0..3 maps to bit 3..0, i.e. bit ~f
  assign jc_taken = flags[~f[1:0]];

  // ALSU: result plus the carry/overflow each function defines
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_ov  = 1'b0;
    case (f)
      3'd0: begin
        alu_res = sum[DATA_W-1:0];
        alu_cy  = sum[DATA_W];
        alu_ov  = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      3'd1: begin
        alu_res = diff[DATA_W-1:0];
        alu_cy  = diff[DATA_W];
        alu_ov  = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      3'd2: alu_res = a & b;
      3'd3: alu_res = a | b;
      3'd4: alu_res = a ^ b;
      3'd5: alu_res = ~a;
      3'd6: begin
        alu_res = {a[DATA_W-2:0], 1'b0};
        alu_cy  = a[MSB];
      end
      default: begin
        alu_res = {1'b0, a[DATA_W-1:1]};
        alu_cy  = a[0];
      end
    endcase
    alu_flags = {alu_cy, alu_ov, alu_res[MSB], (alu_res == '0)};
  end

  // Next-state, next bus request and datapath write strobes
  always_comb begin
    state_n  = state;
    ir_n     = ir;
    pc_n     = pc;
    flags_n  = flags;
    req_n    = mem_req;
    we_n     = mem_we;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    rf_we    = 1'b0;
    rf_wdata = '0;
    case (state)
      S_FETCH: begin
        if (!mem_req) begin
          // idle cycle after an OPER ack (or after reset): raise the fetch now
          req_n  = 1'b1;
          we_n   = 1'b0;
          addr_n = pc;
        end else if (mem_ack) begin
          ir_n    = mem_rdata;
          pc_n    = pc_inc;
          req_n   = 1'b0;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          4'd1: state_n = S_EXEC;
          4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
            state_n = S_OPER;
            req_n   = 1'b1;
            we_n    = (op == 4'd4);
            addr_n  = (op == 4'd3 || op == 4'd4) ? a[ADDR_W-1:0] : pc;
            if (op == 4'd4) wdata_n = b;
          end
          4'd7: state_n = S_HALT;
          default: begin
            state_n = S_FETCH;
            req_n   = 1'b1;
            we_n    = 1'b0;
            addr_n  = pc;
          end
        endcase
      end
      S_EXEC: begin
        rf_we    = 1'b1;
        rf_wdata = alu_res;
        flags_n  = alu_flags;
        state_n  = S_FETCH;
        req_n    = 1'b1;
        we_n     = 1'b0;
        addr_n   = pc;
      end
      S_OPER: begin
        if (mem_req && mem_ack) begin
          req_n   = 1'b0;
          we_n    = 1'b0;
          state_n = S_FETCH;
          case (op)
            4'd2: begin
              rf_we    = 1'b1;
              rf_wdata = mem_rdata;
              pc_n     = pc_inc;
            end
            4'd3: begin
              rf_we    = 1'b1;
              rf_wdata = mem_rdata;
            end
            4'd5: pc_n = mem_rdata[ADDR_W-1:0];
            4'd6: pc_n = jc_taken ? mem_rdata[ADDR_W-1:0] : pc_inc;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // State, architectural registers and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      ir        <= '0;
      pc        <= '0;
      flags     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state     <= state_n;
      ir        <= ir_n;
      pc        <= pc_n;
      flags     <= flags_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      if (rf_we) regs[rd] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_cisc_core_multiciclo.sv
// Bench for cisc_core_multiciclo: scoreboarded bus trace for the default build,
// plus a short program on a 24/12/16 build.
module tb_cisc_core_multiciclo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default build
  logic        rst_n;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0]  flags;

  // wide build
  logic        rst2_n;
  logic        mem_req2, mem_we2, mem_ack2, halted2;
  logic [11:0] mem_addr2, pc2;
  logic [23:0] mem_wdata2, mem_rdata2;
  logic [3:0]  flags2;

  cisc_core_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .halted(halted), .flags(flags), .pc(pc)
  );

  cisc_core_multiciclo #(.DATA_W(24), .ADDR_W(12), .NREG(16)) dut2 (
    .clk(clk), .rst_n(rst2_n), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .mem_ack(mem_ack2), .halted(halted2), .flags(flags2), .pc(pc2)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chkf;
    logic [3:0]  fl;
    int          wt;
  } tr_t;

  tr_t         exp_q[$];
  logic [15:0] mem [256];
  logic [23:0] mem2 [4096];
  int          total = 0, bad = 0;
  int          cyc = 0, n_acks = 0, n_push = 0, wcnt = 0;
  int          ack_cyc [512];
  logic        held_v = 1'b0, h_we;
  logic [15:0] h_addr, h_wdata;
  logic [15:0] pa;
  logic [3:0]  cur_fl;
  int          wr2_cnt = 0;
  logic [11:0] wr2_addr;
  logic [23:0] wr2_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(int op, int rd, int ra, int rb, int f);
    return {4'(op), 3'(rd), 3'(ra), 3'(rb), 3'(f)};
  endfunction

  function automatic logic [23:0] enc2(int op, int rd, int ra, int rb, int f);
    return {4'(op), 4'(rd), 4'(ra), 4'(rb), 5'b0, 3'(f)};
  endfunction

  // ---- program builder: writes memory and pushes the expected bus trace ----
  task automatic push(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                      input logic chkf, input logic [3:0] fl, input int wt);
    tr_t t;
    t.we = we; t.addr = addr; t.wdata = wd; t.chkf = chkf; t.fl = fl; t.wt = wt;
    exp_q.push_back(t);
    n_push++;
  endtask

  task automatic ifetch(input logic [15:0] w);
    push(1'b0, pa, 16'h0, 1'b1, cur_fl, 0);
    mem[pa[7:0]] = w;
    pa++;
  endtask

  task automatic operand(input logic [15:0] w);
    push(1'b0, pa, 16'h0, 1'b0, 4'h0, 0);
    mem[pa[7:0]] = w;
    pa++;
  endtask

  task automatic ldi(input int rd, input logic [15:0] imm);
    ifetch(enc(2, rd, 0, 0, 0));
    operand(imm);
  endtask

  task automatic alu(input int f, input int rd, input int ra, input int rb, input logic [3:0] nf);
    ifetch(enc(1, rd, ra, rb, f));
    cur_fl = nf;
  endtask

  task automatic st(input int ra, input int rb, input logic [15:0] addr,
                    input logic [15:0] data, input int wt);
    ifetch(enc(4, 0, ra, rb, 0));
    push(1'b1, addr, data, 1'b0, 4'h0, wt);
  endtask

  task automatic ld(input int rd, input int ra, input logic [15:0] addr, input int wt);
    ifetch(enc(3, rd, ra, 0, 0));
    push(1'b0, addr, 16'h0, 1'b0, 4'h0, wt);
  endtask

  task automatic jc(input int f, input logic [15:0] tgt, input logic taken);
    ifetch(enc(6, 0, 0, 0, f));
    operand(tgt);
    if (taken) pa = tgt;
  endtask

  task automatic jmp(input logic [15:0] tgt);
    ifetch(enc(5, 0, 0, 0, 0));
    operand(tgt);
    pa = tgt;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory responder + scoreboard; acks spuriously whenever no request is up
  always @(negedge clk) begin
    if (mem_req) begin
      if (held_v) begin
        chk("hold_addr", mem_addr, h_addr);
        chk("hold_we", mem_we, h_we);
        chk("hold_wdata", mem_wdata, h_wdata);
      end
      chk("tr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0 && wcnt < exp_q[0].wt) begin
        wcnt++;
        mem_ack = 1'b0;
        held_v = 1'b1;
        h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
      end else begin
        if (exp_q.size() != 0) begin
          tr_t e;
          e = exp_q.pop_front();
          chk("tr_addr", mem_addr, e.addr);
          chk("tr_we", mem_we, e.we);
          if (e.we) chk("tr_wdata", mem_wdata, e.wdata);
          if (e.chkf) chk("flags_at_fetch", flags, e.fl);
        end
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr[7:0]];
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
        if (n_acks < 512) ack_cyc[n_acks] = cyc;
        n_acks++;
        wcnt = 0;
        held_v = 1'b0;
      end
    end else begin
      mem_ack = 1'b1;
      mem_rdata = 16'hDEAD;
      wcnt = 0;
      held_v = 1'b0;
    end
  end

  // zero-wait responder for the wide build
  always @(negedge clk) begin
    if (mem_req2) begin
      mem_ack2 = 1'b1;
      mem_rdata2 = mem2[mem_addr2];
      if (mem_we2) begin
        mem2[mem_addr2] = mem_wdata2;
        wr2_cnt++;
        wr2_addr = mem_addr2;
        wr2_data = mem_wdata2;
      end
    end else begin
      mem_ack2 = 1'b0;
      mem_rdata2 = '0;
    end
  end

  int idx_ldi, idx_alu, idx_st, idx_ld, idx_nop, base;

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; mem_ack2 = 1'b0; mem_rdata2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    pa = 16'h0;
    cur_fl = 4'h0;

    // ---- main program ----
    idx_ldi = n_push;
    ldi(1, 16'h7FFF);
    ldi(2, 16'h0001);
    idx_alu = n_push;
    alu(0, 3, 1, 2, 4'b0110);            // 0x7FFF+1 = 0x8000
    alu(1, 4, 2, 2, 4'b0001);            // 1-1 = 0
    jc(3, 16'h0040, 1'b1);               // z=1 -> taken
    jc(0, 16'h0080, 1'b0);               // cy=0 -> falls to +2
    idx_st = n_push;
    st(2, 1, 16'h0001, 16'h7FFF, 2);
    idx_ld = n_push;
    ld(5, 2, 16'h0001, 2);
    st(4, 5, 16'h0000, 16'h7FFF, 0);
    st(4, 3, 16'h0000, 16'h8000, 0);
    idx_nop = n_push;
    ifetch(enc(0, 0, 0, 0, 0));
    ifetch(enc(9, 1, 1, 1, 1));
    alu(2, 6, 1, 3, 4'b0001); st(4, 6, 16'h0000, 16'h0000, 0);
    alu(3, 6, 1, 3, 4'b0010); st(4, 6, 16'h0000, 16'hFFFF, 0);
    alu(4, 7, 3, 2, 4'b0010); st(4, 7, 16'h0000, 16'h8001, 0);
    alu(5, 7, 1, 0, 4'b0010); st(4, 7, 16'h0000, 16'h8000, 0);
    alu(6, 6, 3, 0, 4'b1001); st(4, 6, 16'h0000, 16'h0000, 0);
    alu(7, 6, 2, 0, 4'b1001); st(4, 6, 16'h0000, 16'h0000, 0);
    alu(1, 6, 2, 1, 4'b1010); st(4, 6, 16'h0000, 16'h8002, 0);
    alu(1, 6, 3, 2, 4'b0100); st(4, 6, 16'h0000, 16'h7FFF, 0);
    alu(0, 6, 3, 3, 4'b1101); st(4, 6, 16'h0000, 16'h0000, 0);
    jc(2, 16'h0090, 1'b0);               // msb=0
    jc(0, 16'h00A0, 1'b1);               // cy=1
    jmp(16'h00B0);
    ifetch(enc(7, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 0);
    chk("first_we", mem_we, 0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (halted) break;
    end
    chk("halt_reached", halted, 1);
    chk("trace_drained", exp_q.size(), 0);
    chk("halt_pc", pc, 16'h00B1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("halt_req_low", mem_req, 0);
    end

    chk("lat_ldi_oper", ack_cyc[idx_ldi+1] - ack_cyc[idx_ldi], 2);
    chk("lat_alu", ack_cyc[idx_alu+1] - ack_cyc[idx_alu], 3);
    chk("lat_st_wait2", ack_cyc[idx_st+1] - ack_cyc[idx_st], 4);
    chk("lat_ld_wait2", ack_cyc[idx_ld+1] - ack_cyc[idx_ld], 4);
    chk("lat_nop", ack_cyc[idx_nop+1] - ack_cyc[idx_nop], 2);
    chk("lat_illegal", ack_cyc[idx_nop+2] - ack_cyc[idx_nop+1], 2);

    // ---- reset in the middle of an LD operand transfer ----
    @(negedge clk);
    rst_n = 1'b0;
    pa = 16'h0;
    cur_fl = 4'h0;
    ld(3, 0, 16'h0000, 0);
    base = n_acks;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (n_acks == base + 2) break;
    end
    chk("oper_ack_seen", n_acks, base + 2);
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", mem_req, 0);
    chk("rst_pc_mid", pc, 0);
    pa = 16'h0;
    st(0, 3, 16'h0000, 16'h0000, 0);     // r3 must still be the reset value
    ifetch(enc(7, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (halted) break;
    end
    chk("halt2_reached", halted, 1);
    chk("trace2_drained", exp_q.size(), 0);

    // ---- wide build: pc wrap and SHL carry-out ----
    mem2[12'h000] = enc2(5, 0, 0, 0, 0);
    mem2[12'h001] = 24'h000FFA;
    mem2[12'hFFA] = enc2(2, 1, 0, 0, 0);
    mem2[12'hFFB] = 24'h800000;
    mem2[12'hFFC] = enc2(1, 2, 1, 0, 6);
    mem2[12'hFFD] = enc2(4, 0, 3, 2, 0);
    mem2[12'hFFE] = enc2(0, 0, 0, 0, 0);
    mem2[12'hFFF] = enc2(7, 0, 0, 0, 0);
    @(negedge clk);
    rst2_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (halted2) break;
    end
    chk("w_halted", halted2, 1);
    chk("w_pc_wrap", pc2, 12'h000);
    chk("w_flags_shl", flags2, 4'b1001);
    chk("w_wr_count", wr2_cnt, 1);
    chk("w_wr_addr", wr2_addr, 12'h000);
    chk("w_wr_data", wr2_data, 24'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
